lift_row_53: RTL and testbench

LIFT_ROW_53 -- requirements
Module: lift_row_53

---
 rtl/lift_pkg.sv | 13 +
 rtl/lift_step.sv | 22 ++
 rtl/lift_row_53.sv | 74 +++++++
 tb/tb_lift_row_53.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// lift_pkg: state encoding, mode constants and rounding helper shared by the 5/3 lifting row
package lift_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PASS1 = 3'd2;
    localparam logic [2:0] S_PASS2 = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic MODE_FWD = 1'b1;
    localparam logic MODE_INV = 1'b0;
    function automatic logic [1:0] lift_round(input logic odd);
        return odd ? 2'd0 : 2'd2;
    endfunction
endpackage

// File: rtl/lift_step.sv
// lift_step: one 5/3 lifting step for a single element (predict on odd, update on even)
module lift_step
    import lift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] l,
    input  logic signed [WIDTH-1:0] r,
    input  logic signed [WIDTH-1:0] s,
    input  logic                    odd,
    input  logic                    fwd,
    output logic signed [WIDTH-1:0] res
);
    logic signed [WIDTH+1:0] sum;
    logic signed [WIDTH+1:0] d;
    always_comb begin
        sum = (WIDTH+2)'(l) + (WIDTH+2)'(r) + (WIDTH+2)'($signed({1'b0, lift_round(odd)}));
        d   = odd ? sum >>> 1 : sum >>> 2;
        // forward predict subtracts, forward update adds; inverse swaps both
        res = WIDTH'((odd ^ fwd) ? (WIDTH+2)'(s) + d : (WIDTH+2)'(s) - d);
    end
endmodule

// File: rtl/lift_row_53.sv
// lift_row_53: buffers one row, runs in-place 5/3 lifting in two passes, then streams it out
module lift_row_53
    import lift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode_i,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
);
    localparam int AW = $clog2(LEN);
    logic [2:0] state;
    logic [AW-1:0] cnt;
    logic mode;
    logic signed [WIDTH-1:0] mem [LEN];
    logic pass, par, last_half, last_all;
    logic [AW-1:0] idx;
    logic signed [WIDTH-1:0] lft, rgt, res;
    assign in_ready  = state == S_IDLE || state == S_LOAD;
    assign pass      = state == S_PASS1 || state == S_PASS2;
    assign par       = state == S_PASS1 ? mode : ~mode;
    assign idx       = {cnt[AW-2:0], par};
    assign last_half = cnt == AW'(LEN/2 - 1);
    assign last_all  = cnt == AW'(LEN - 1);
    // symmetric extension: x[-1] mirrors x[1], x[LEN] mirrors x[LEN-2]
    assign lft       = idx == '0 ? mem[AW'(1)] : mem[idx - AW'(1)];
    assign rgt       = idx == AW'(LEN - 1) ? mem[AW'(LEN - 2)] : mem[idx + AW'(1)];
    assign out_valid = state == S_OUT;
    assign out_last  = out_valid && last_all;
    assign out_data  = out_valid ? mem[cnt] : '0;
    assign busy      = state != S_IDLE;
    lift_step #(.WIDTH(WIDTH)) u_step (
        .l  (lft),
        .r  (rgt),
        .s  (mem[idx]),
        .odd(idx[0]),
        .fwd(mode == MODE_FWD),
        .res(res)
    );
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) mem[cnt] <= in_data;
        else if (pass) mem[idx] <= res;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            mode  <= MODE_FWD;
        end else begin
            if ((in_ready && in_valid) || pass || (out_valid && out_ready))
                cnt <= (pass && last_half) ? '0 : cnt + AW'(1);
            case (state)
                S_IDLE:  if (in_valid) begin
                    state <= S_LOAD;
                    mode  <= mode_i;
                end
                S_LOAD:  if (in_valid && last_all) state <= S_PASS1;
                S_PASS1: if (last_half) state <= S_PASS2;
                S_PASS2: if (last_half) state <= S_OUT;
                S_OUT:   if (out_ready && last_all) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lift_row_53.sv
// tb_lift_row_53: directed checks on three configurations (16b/8, 16b/64, 8b/8)
module tb_lift_row_53;
    typedef logic signed [15:0] row_t [64];
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_vec = 0;
    int n_bad = 0;
    logic iv [3];
    logic md [3];
    logic orr [3];
    logic ir [3];
    logic ov [3];
    logic ol [3];
    logic bz [3];
    logic [15:0] id [3];
    logic signed [15:0] od [3];
    logic signed [15:0] a_od, b_od;
    logic signed [7:0] c_od;
    assign od[0] = a_od;
    assign od[1] = b_od;
    assign od[2] = {{8{c_od[7]}}, c_od};

    lift_row_53 #(.WIDTH(16), .LEN(8)) u_a (
        .clk(clk), .rst_n(rst_n), .mode_i(md[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(a_od),
        .out_last(ol[0]), .busy(bz[0]));
    lift_row_53 #(.WIDTH(16), .LEN(64)) u_b (
        .clk(clk), .rst_n(rst_n), .mode_i(md[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(b_od),
        .out_last(ol[1]), .busy(bz[1]));
    lift_row_53 #(.WIDTH(8), .LEN(8)) u_c (
        .clk(clk), .rst_n(rst_n), .mode_i(md[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2][7:0]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(c_od),
        .out_last(ol[2]), .busy(bz[2]));

    function automatic int wrap(input int a, input int w);
        int t;
        t = a <<< (32 - w);
        return t >>> (32 - w);
    endfunction

    // reference 5/3 lifting with integer arithmetic and explicit wrap to w bits
    task automatic model(input logic fwd, input int n, input int w, input row_t x, output row_t y);
        int v [64];
        int l, r, d, i;
        logic odd;
        for (int j = 0; j < 64; j++) v[j] = (j < n) ? int'(x[j]) : 0;
        for (int p = 0; p < 2; p++) begin
            odd = fwd ? (p == 0) : (p == 1);
            for (i = odd ? 1 : 0; i < n; i += 2) begin
                l = (i == 0) ? v[1] : v[i-1];
                r = (i == n - 1) ? v[n-2] : v[i+1];
                if (odd) begin
                    d = (l + r) >>> 1;
                    v[i] = wrap(fwd ? v[i] - d : v[i] + d, w);
                end else begin
                    d = (l + r + 2) >>> 2;
                    v[i] = wrap(fwd ? v[i] + d : v[i] - d, w);
                end
            end
        end
        for (int j = 0; j < 64; j++) y[j] = 16'(v[j]);
    endtask

    task automatic send_row(input int sel, input logic m, input int n, input row_t x, output int acc);
        int t;
        acc = -1;
        for (int i = 0; i < n; i++) begin
            iv[sel] = 1'b1;
            id[sel] = x[i];
            md[sel] = (i == 0) ? m : ~m;
            t = 0;
            while (!ir[sel] && t < 300) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 300) begin
                n_vec++;
                n_bad++;
                $display("FAIL send_timeout dut=%0d sample=%0d in_ready stayed low", sel, i);
            end
            acc = cyc;
            @(posedge clk);
            #1;
        end
        iv[sel] = 1'b0;
    endtask

    task automatic recv_row(input int sel, input int n, input logic stall, output row_t y,
                            output logic lst [64], output int first, output int hold_bad);
        int got, t, k;
        logic held;
        logic signed [15:0] hv;
        got = 0; t = 0; k = 0; held = 1'b0; hv = '0;
        first = -1;
        hold_bad = 0;
        for (int j = 0; j < 64; j++) begin
            y[j] = '0;
            lst[j] = 1'b0;
        end
        while (got < n && t < 2000) begin
            orr[sel] = stall ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            if (ov[sel]) begin
                k++;
                if (first < 0) first = cyc;
                if (held && od[sel] !== hv) hold_bad++;
                if (orr[sel]) begin
                    y[got] = od[sel];
                    lst[got] = ol[sel];
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hv = od[sel];
                end
            end
            @(posedge clk);
            #1;
            t++;
        end
        orr[sel] = 1'b1;
        if (got < n) begin
            n_vec++;
            n_bad++;
            $display("FAIL recv_timeout dut=%0d got=%0d want=%0d", sel, got, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            n_vec += 5;
            if (bz[s] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut=%0d got=%b want=0", s, bz[s]); end
            if (ov[s] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid dut=%0d got=%b want=0", s, ov[s]); end
            if (ol[s] !== 1'b0) begin n_bad++; $display("FAIL reset_out_last dut=%0d got=%b want=0", s, ol[s]); end
            if (ir[s] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready dut=%0d got=%b want=1", s, ir[s]); end
            if (od[s] !== 16'sd0) begin n_bad++; $display("FAIL reset_out_data dut=%0d got=%0d want=0", s, od[s]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fwd8(input logic stall);
        row_t x, y;
        logic lst [64];
        int acc, first, hb;
        int e [8] = '{0, 0, 2, 0, 4, 0, 6, 1};
        for (int i = 0; i < 8; i++) x[i] = 16'(i);
        send_row(0, 1'b1, 8, x, acc);
        recv_row(0, 8, stall, y, lst, first, hb);
        for (int i = 0; i < 8; i++) begin
            n_vec += 2;
            if (y[i] !== 16'(e[i])) begin n_bad++; $display("FAIL fwd8_data stall=%b i=%0d got=%0d want=%0d", stall, i, y[i], e[i]); end
            if (lst[i] !== (i == 7)) begin n_bad++; $display("FAIL fwd8_last stall=%b i=%0d got=%b want=%b", stall, i, lst[i], i == 7); end
        end
        n_vec += 3;
        if (hb !== 0) begin n_bad++; $display("FAIL fwd8_hold stall=%b changes_while_stalled=%0d want=0", stall, hb); end
        if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL fwd8_ready_after got=%b want=1", ir[0]); end
        if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL fwd8_busy_after got=%b want=0", bz[0]); end
    endtask

    task automatic test_inv8();
        row_t x, y;
        logic lst [64];
        int acc, first, hb;
        int e [8] = '{0, 0, 2, 0, 4, 0, 6, 1};
        for (int i = 0; i < 8; i++) x[i] = 16'(e[i]);
        send_row(0, 1'b0, 8, x, acc);
        recv_row(0, 8, 1'b0, y, lst, first, hb);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (y[i] !== 16'(i)) begin n_bad++; $display("FAIL inv8_data i=%0d got=%0d want=%0d", i, y[i], i); end
        end
    endtask

    task automatic test_len64();
        row_t x, y, m;
        logic lst [64];
        int acc, first, hb;
        for (int i = 0; i < 64; i++) x[i] = 16'sd216;
        send_row(1, 1'b1, 64, x, acc);
        recv_row(1, 64, 1'b0, y, lst, first, hb);
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if (y[i] !== ((i % 2 == 0) ? 16'sd216 : 16'sd0)) begin
                n_bad++;
                $display("FAIL const64 i=%0d got=%0d want=%0d", i, y[i], (i % 2 == 0) ? 216 : 0);
            end
        end
        for (int i = 0; i < 64; i++) x[i] = (i % 2 == 1) ? 16'sd216 : (i % 4 == 0) ? 16'sd215 : 16'sd217;
        model(1'b1, 64, 16, x, m);
        send_row(1, 1'b1, 64, x, acc);
        recv_row(1, 64, 1'b0, y, lst, first, hb);
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if (y[i] !== m[i]) begin n_bad++; $display("FAIL alt64 i=%0d got=%0d want=%0d", i, y[i], m[i]); end
            if (i % 2 == 1 && i < 63) begin
                n_vec++;
                if (y[i] !== 16'sd0) begin n_bad++; $display("FAIL alt64_odd_zero i=%0d got=%0d want=0", i, y[i]); end
            end
        end
        n_vec++;
        if (first - acc !== 65) begin n_bad++; $display("FAIL latency64 got=%0d want=65", first - acc); end
    endtask

    task automatic test_reset_mid();
        row_t x, y;
        logic lst [64];
        int acc, first, hb;
        for (int i = 0; i < 8; i++) x[i] = 16'(i * 3 - 5);
        send_row(0, 1'b1, 8, x, acc);
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (bz[0] !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got=%b want=1", bz[0]); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_vec += 3;
        if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b want=0", bz[0]); end
        if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid got=%b want=0", ov[0]); end
        if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready got=%b want=1", ir[0]); end
        test_inv8();
    endtask

    task automatic test_wrap8();
        row_t x, y, m, z;
        logic lst [64];
        int acc, first, hb;
        for (int i = 0; i < 8; i++) x[i] = (i % 2 == 0) ? 16'sd127 : -16'sd128;
        model(1'b1, 8, 8, x, m);
        send_row(2, 1'b1, 8, x, acc);
        recv_row(2, 8, 1'b0, y, lst, first, hb);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (y[i] !== m[i]) begin n_bad++; $display("FAIL wrap_fwd i=%0d got=%0d want=%0d", i, y[i], m[i]); end
        end
        send_row(2, 1'b0, 8, m, acc);
        recv_row(2, 8, 1'b0, z, lst, first, hb);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (z[i] !== x[i]) begin n_bad++; $display("FAIL wrap_inv i=%0d got=%0d want=%0d", i, z[i], x[i]); end
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            iv[s] = 1'b0;
            md[s] = 1'b0;
            orr[s] = 1'b1;
            id[s] = '0;
        end
        test_reset();
        test_fwd8(1'b0);
        test_inv8();
        test_len64();
        test_fwd8(1'b1);
        test_reset_mid();
        test_wrap8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
